// File: rtl/cache_arbiter_pkg.sv
// rtl/cache_arbiter_pkg.sv - shared state/grant types and default widths for the cache arbiter
package arb_types;
    localparam int CACHELINE_W = 256;
    localparam int ADDR_W      = 32;

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RELEASE} arb_state_t;
    typedef enum logic [1:0] {GNT_NONE, GNT_I, GNT_D} arb_grant_t;
endpackage

// File: rtl/cache_arbiter_pick.sv
// rtl/cache_arbiter_pick.sv - combinational winner selector; round-robin when CACHE_ARB_ROUND_ROBIN_EN is defined
module arb_pick
    import arb_types::*;
(
    input  logic       i_req,
    input  logic       d_req,
    input  logic       last_grant,
    output arb_grant_t grant
);

`ifndef CACHE_ARB_ROUND_ROBIN_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

    // last_grant: 1 means the dcache was served last
    always_comb begin
        grant = GNT_NONE;
        if (i_req && d_req) begin
`ifdef CACHE_ARB_ROUND_ROBIN_EN
            grant = last_grant ? GNT_I : GNT_D;
`else
            grant = GNT_D;
`endif
        end else if (d_req) begin
            grant = GNT_D;
        end else if (i_req) begin
            grant = GNT_I;
        end
    end
endmodule

// File: rtl/cache_arbiter.sv
// rtl/cache_arbiter.sv - shares one cacheline adaptor port between icache and dcache (CACHE_ARB_ROUND_ROBIN_EN selects round-robin)
module cache_arbiter #(
    parameter int LINE_W = arb_types::CACHELINE_W,
    parameter int ADDR_W = arb_types::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    arb_types::arb_state_t state_q, state_d;
    arb_types::arb_grant_t grant_q, grant_d, pick;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              last_grant;

`ifdef CACHE_ARB_ROUND_ROBIN_EN
    logic last_grant_q, last_grant_d;
    assign last_grant = last_grant_q;
`else
    assign last_grant = 1'b0;
`endif

    arb_pick u_pick (
        .i_req      (i_read),
        .d_req      (d_read | d_write),
        .last_grant (last_grant),
        .grant      (pick)
    );

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        mem_read_d    = mem_read_q;
        mem_write_d   = mem_write_q;
        mem_address_d = mem_address_q;
        mem_wdata_d   = mem_wdata_q;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
        last_grant_d  = last_grant_q;
`endif
        case (state_q)
            arb_types::IDLE: begin
                if (pick == arb_types::GNT_D) begin
                    state_d       = arb_types::SERVE_D;
                    grant_d       = arb_types::GNT_D;
                    mem_address_d = d_address;
                    mem_wdata_d   = d_wdata;
                    // read+write together is a protocol error; the writeback wins
                    mem_write_d   = d_write;
                    mem_read_d    = ~d_write;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
                    last_grant_d  = 1'b1;
`endif
                end else if (pick == arb_types::GNT_I) begin
                    state_d       = arb_types::SERVE_I;
                    grant_d       = arb_types::GNT_I;
                    mem_address_d = i_address;
                    mem_wdata_d   = '0;
                    mem_write_d   = 1'b0;
                    mem_read_d    = 1'b1;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
                    last_grant_d  = 1'b0;
`endif
                end
            end
            arb_types::SERVE_I, arb_types::SERVE_D: begin
                if (mem_resp) begin
                    state_d     = arb_types::RELEASE;
                    grant_d     = arb_types::GNT_NONE;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                end
            end
            arb_types::RELEASE: state_d = arb_types::IDLE;
            default:            state_d = arb_types::IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= arb_types::IDLE;
            grant_q       <= arb_types::GNT_NONE;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_address_q <= '0;
            mem_wdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            mem_address_q <= mem_address_d;
            mem_wdata_q   <= mem_wdata_d;
        end
    end

`ifdef CACHE_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) last_grant_q <= 1'b0;
        else      last_grant_q <= last_grant_d;
    end
`endif

    // grant is GNT_NONE outside SERVE_x, so stray responses never reach a cache
    assign i_resp      = mem_resp && (grant_q == arb_types::GNT_I);
    assign d_resp      = mem_resp && (grant_q == arb_types::GNT_D);
    assign i_rdata     = mem_rdata;
    assign d_rdata     = mem_rdata;
    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign mem_address = mem_address_q;
    assign mem_wdata   = mem_wdata_q;
endmodule

// File: tb/tb_cache_arbiter.sv
// tb/tb_cache_arbiter.sv - directed self-checking bench for cache_arbiter (honours CACHE_ARB_ROUND_ROBIN_EN)
module tb_cache_arbiter;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         i_read = 1'b0;
    logic [31:0]  i_address = '0;
    logic [255:0] i_rdata;
    logic         i_resp;
    logic         d_read = 1'b0;
    logic         d_write = 1'b0;
    logic [31:0]  d_address = '0;
    logic [255:0] d_wdata = '0;
    logic [255:0] d_rdata;
    logic         d_resp;
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_address;
    logic [255:0] mem_wdata;
    logic [255:0] mem_rdata = '0;
    logic         mem_resp = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    int rd_pulses = 0;
    logic rd_prev = 1'b0;

    cache_arbiter dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_read && !rd_prev) rd_pulses++;
        rd_prev = mem_read;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic respond(input int n, input logic [255:0] data);
        repeat (n) tick();
        mem_resp  = 1'b1;
        mem_rdata = data;
        #1;
    endtask

    task automatic finish_txn();
        tick();
        mem_resp  = 1'b0;
        mem_rdata = '0;
        #1;
        chk("release_rd", mem_read, 1'b0);
        chk("release_wr", mem_write, 1'b0);
        tick();
    endtask

    int   base;
    bit   exp_d;

    initial begin
        #3;
        chk("rst_mem_read", mem_read, 1'b0);
        chk("rst_mem_write", mem_write, 1'b0);
        chk("rst_mem_address", mem_address, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 256'h0);
        chk("rst_i_resp", i_resp, 1'b0);
        chk("rst_d_resp", d_resp, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // lone icache read, adaptor answers after 5 cycles
        i_read = 1'b1;
        i_address = 32'h6000_0040;
        tick();
        chk("t1_mem_read", mem_read, 1'b1);
        chk("t1_mem_write", mem_write, 1'b0);
        chk("t1_mem_address", mem_address, 32'h6000_0040);
        respond(4, {32{8'hA5}});
        chk("t1_mem_read_held", mem_read, 1'b1);
        chk("t1_i_resp", i_resp, 1'b1);
        chk("t1_i_rdata", i_rdata, {32{8'hA5}});
        chk("t1_d_resp", d_resp, 1'b0);
        i_read = 1'b0;
        finish_txn();
        chk("t1_idle_rd", mem_read, 1'b0);

        // simultaneous requests: dcache first, then icache
        base = rd_pulses;
        i_read = 1'b1;
        i_address = 32'h6000_0080;
        d_read = 1'b1;
        d_address = 32'h0000_2000;
        tick();
        chk("t2_d_addr", mem_address, 32'h0000_2000);
        chk("t2_d_rd", mem_read, 1'b1);
        respond(2, {8{32'hBEEF_0001}});
        chk("t2_d_resp", d_resp, 1'b1);
        chk("t2_i_resp_quiet", i_resp, 1'b0);
        chk("t2_d_rdata", d_rdata, {8{32'hBEEF_0001}});
        d_read = 1'b0;
        finish_txn();
        tick();
        chk("t2_i_addr", mem_address, 32'h6000_0080);
        chk("t2_i_rd", mem_read, 1'b1);
        respond(3, {8{32'hCAFE_0002}});
        chk("t2_i_resp", i_resp, 1'b1);
        chk("t2_d_resp_quiet", d_resp, 1'b0);
        i_read = 1'b0;
        finish_txn();
        chk("t2_pulses", rd_pulses - base, 2);

        // repeated contention: last served was icache, so dcache wins first
        i_read = 1'b1;
        i_address = 32'h6000_0300;
        d_read = 1'b1;
        d_address = 32'h0000_4000;
        for (int r = 0; r < 4; r++) begin
`ifdef CACHE_ARB_ROUND_ROBIN_EN
            exp_d = (r % 2 == 0);
`else
            exp_d = 1'b1;
`endif
            tick();
            chk("t3_addr", mem_address, exp_d ? 32'h0000_4000 : 32'h6000_0300);
            respond(1, {8{32'h0000_0100 + r}});
            chk("t3_d_resp", d_resp, exp_d);
            chk("t3_i_resp", i_resp, !exp_d);
            finish_txn();
        end
        i_read = 1'b0;
        d_read = 1'b0;
        tick();

        // writeback with icache request arriving mid-transaction
        d_write = 1'b1;
        d_address = 32'h0000_1F20;
        d_wdata = {8{32'h1234_5678}};
        tick();
        chk("t4_wr", mem_write, 1'b1);
        chk("t4_rd", mem_read, 1'b0);
        chk("t4_addr", mem_address, 32'h0000_1F20);
        chk("t4_wdata", mem_wdata, {8{32'h1234_5678}});
        i_read = 1'b1;
        i_address = 32'h6000_0100;
        d_wdata = {8{32'hDEAD_DEAD}};
        tick();
        tick();
        chk("t4_wdata_held", mem_wdata, {8{32'h1234_5678}});
        chk("t4_addr_held", mem_address, 32'h0000_1F20);
        chk("t4_rd_held", mem_read, 1'b0);
        respond(0, '0);
        chk("t4_d_resp", d_resp, 1'b1);
        chk("t4_i_resp", i_resp, 1'b0);
        d_write = 1'b0;
        finish_txn();
        chk("t4_idle_rd", mem_read, 1'b0);
        tick();
        chk("t4_i_rd", mem_read, 1'b1);
        chk("t4_i_addr", mem_address, 32'h6000_0100);
        respond(1, {8{32'h0F0F_0F0F}});
        chk("t4_i_resp2", i_resp, 1'b1);
        i_read = 1'b0;
        finish_txn();

        // asynchronous reset in the middle of SERVE_D
        d_read = 1'b1;
        d_address = 32'h0000_3000;
        tick();
        chk("t5_rd_before", mem_read, 1'b1);
        #2;
        rst = 1'b0;
        d_read = 1'b0;
        mem_resp = 1'b1;
        #1;
        chk("t5_rd_async", mem_read, 1'b0);
        chk("t5_wr_async", mem_write, 1'b0);
        chk("t5_d_resp_async", d_resp, 1'b0);
        chk("t5_i_resp_async", i_resp, 1'b0);
        mem_resp = 1'b0;
        #2;
        rst = 1'b1;
        tick();
        i_read = 1'b1;
        i_address = 32'h6000_0200;
        tick();
        chk("t5_i_rd", mem_read, 1'b1);
        chk("t5_i_addr", mem_address, 32'h6000_0200);
        respond(1, {8{32'h5555_AAAA}});
        chk("t5_i_resp", i_resp, 1'b1);
        i_read = 1'b0;
        finish_txn();

        // protocol errors: read+write together, stray response in IDLE
        d_read = 1'b1;
        d_write = 1'b1;
        d_address = 32'h0000_5000;
        d_wdata = {8{32'h7777_0000}};
        tick();
        chk("t6_wr", mem_write, 1'b1);
        chk("t6_rd", mem_read, 1'b0);
        respond(0, '0);
        chk("t6_d_resp", d_resp, 1'b1);
        d_read = 1'b0;
        d_write = 1'b0;
        finish_txn();
        mem_resp = 1'b1;
        #1;
        chk("t6_stray_i", i_resp, 1'b0);
        chk("t6_stray_d", d_resp, 1'b0);
        tick();
        chk("t6_stray_rd", mem_read, 1'b0);
        mem_resp = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/cache_arbiter.md
Name: cache_arbiter

Overview:
- Shares the single cacheline port to the physical-memory burst adaptor between the icache (read-only) and the dcache (read and writeback).
- Sits between both caches and the cacheline adaptor that drives pmem_*.
- Grants one whole-line transaction at a time; forwards the response only to the granted cache.
- Fixed dcache priority by default; round-robin is optional.

Parameters:
- LINE_W, 256, cacheline width in bits.
- ADDR_W, 32, byte address width; line-aligned addresses are passed through unchanged.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low (asserted when 0)
- i_read  in  1  icache line read request
- i_address  in  ADDR_W  icache line address
- i_rdata  out  LINE_W  line data to icache
- i_resp  out  1  icache transaction complete
- d_read  in  1  dcache line read request
- d_write  in  1  dcache line writeback request
- d_address  in  ADDR_W  dcache line address
- d_wdata  in  LINE_W  dcache writeback data
- d_rdata  out  LINE_W  line data to dcache
- d_resp  out  1  dcache transaction complete
- mem_read  out  1  adaptor read request
- mem_write  out  1  adaptor write request
- mem_address  out  ADDR_W  adaptor line address
- mem_wdata  out  LINE_W  adaptor write data
- mem_rdata  in  LINE_W  adaptor read data
- mem_resp  in  1  adaptor transaction complete

Behaviour:
- State machine states: IDLE, SERVE_I, SERVE_D, RELEASE. Grant is registered.
- Reset (rst=0, async): state=IDLE, grant=none; mem_read=0, mem_write=0, mem_address=0, mem_wdata=0; i_resp=0, d_resp=0. A transaction in flight is abandoned; the adaptor is reset by the same rst.
- IDLE, grant selection:
  - d_read|d_write only → SERVE_D.
  - i_read only → SERVE_I.
  - Both pending → SERVE_D (fixed priority).
- On grant, at the clock edge:
  - mem_address, mem_wdata and the op are latched from the winner.
  - mem_read/mem_write assert the cycle after the request is sampled (1-cycle issue latency).
  - Outputs are held stable until mem_resp.
- SERVE_x:
  - On mem_resp=1: x_resp=1 in the same cycle (combinational: mem_resp & grant==x); x_rdata=mem_rdata in the same cycle.
  - Next cycle → RELEASE; mem_read/mem_write deassert at that edge.
  - The non-granted resp is always 0.
- RELEASE: one dead cycle so the served cache can drop its request. Grant cleared. → IDLE.
- i_rdata and d_rdata both carry mem_rdata at all times; only the resp lines qualify the data.
- Minimum transaction: 1 issue + adaptor latency + 1 release cycle. Back-to-back grants are separated by exactly one RELEASE cycle.
- d_read and d_write both high: protocol error; treated as write (mem_write=1, mem_read=0).
- Requester deasserts before resp: protocol error; the transaction still completes and resp still pulses.
- Request inputs are ignored while not in IDLE; addresses and data are captured only at grant.
- mem_resp while in IDLE/RELEASE: ignored; no resp is forwarded.

Optional Feature:
- Macro: CACHE_ARB_ROUND_ROBIN_EN.
- Defined:
  - A 1-bit last_grant register is added, reset to I.
  - When both requests are pending in IDLE, the requester not served last wins.
  - last_grant updates on each grant.
  - A lone requester always wins.
- Undefined: fixed dcache priority; no last_grant register.

Decomposition:
- Package arb_types holds:
  - arb_state_t enum {IDLE, SERVE_I, SERVE_D, RELEASE}.
  - arb_grant_t enum {GNT_NONE, GNT_I, GNT_D}.
  - Localparams CACHELINE_W=256 and ADDR_W=32, used as parameter defaults.
- One sub-module is natural: arb_pick, a combinational winner selector taking i_req, d_req and last_grant and producing arb_grant_t. It isolates the priority/round-robin policy from the FSM.

Test Plan:
- Lone icache read: i_read=1, i_address=0x6000_0040; adaptor resp after 5 cycles with rdata=0xA5..A5 → mem_read=1 from cycle+1, mem_address=0x6000_0040; i_resp=1 one cycle with i_rdata=0xA5..A5; d_resp stays 0; RELEASE, then IDLE.
- Simultaneous i_read and d_read, macro off:
  - Dcache served first; i_resp=0 during it.
  - After RELEASE, icache granted with its address.
  - Total of 2 mem_read pulses.
- Simultaneous requests repeated 4 times, macro on → grant order D, I, D, I (last_grant reset=I); without macro → D each round while dcache re-requests.
- Dcache writeback: d_write=1, d_address=0x0000_1F20, d_wdata=0x1234...; a new i_read arrives mid-transaction → mem_write=1 with latched data stable until resp; mem_read=0 throughout; icache served only after RELEASE.
- Async reset asserted mid SERVE_D (rst=0 between edges) → mem_read, mem_write and all resp drop to 0 immediately, without waiting for clk; after release, IDLE accepts a new i_read normally.
- Protocol errors:
  - d_read=d_write=1 → write issued.
  - Stray mem_resp in IDLE → no i_resp/d_resp pulse.
